// File: rtl/frame_writer_if.sv
// frame_writer_if: per-channel sample stream feeding the frame writer.
//   in_valid : sample present on in_data this edge
//   in_sync  : qualifies in_valid, the sample is channel 0
//   in_data  : 16-bit two's complement sample
//   master drives the stream, slave (frame_writer) consumes it.
interface frame_writer_if;
    logic        in_valid;
    logic        in_sync;
    logic [15:0] in_data;
    modport master (output in_valid, in_sync, in_data);
    modport slave  (input  in_valid, in_sync, in_data);
endinterface

// File: rtl/frame_writer.sv
// frame_writer: writes a sample stream into the frame-organised audio RAM and launches one sequencer pass per frame.
//   ck, rst  : falling-edge clock, asynchronous active-high reset
//   src      : sample stream (in_valid, in_sync, in_data)
//   clr      : clears the sticky overrun / sync_err flags
//   seq_done : sequencer done
//   we, waddr, wdata : audio RAM write port, waddr = {wframe, chan}
//   frame    : most recently completed frame index
//   seq_run  : sequencer run (high = run)
//   overrun, sync_err : sticky error flags
module frame_writer #(
    parameter int FRAME_W = 4,
    parameter int CHAN_W  = 4,
    parameter int NCHAN   = 8,
    parameter int GAP     = 2
) (
    input  logic                      ck,
    input  logic                      rst,
    frame_writer_if.slave             src,
    input  logic                      clr,
    input  logic                      seq_done,
    output logic                      we,
    output logic [FRAME_W+CHAN_W-1:0] waddr,
    output logic [15:0]               wdata,
    output logic [FRAME_W-1:0]        frame,
    output logic                      seq_run,
    output logic                      overrun,
    output logic                      sync_err
);
    localparam int GAP_W = $clog2(GAP + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    state_t                    state_q, state_d;
    logic                      we_q, we_d;
    logic [FRAME_W+CHAN_W-1:0] waddr_q, waddr_d;
    logic [15:0]               wdata_q, wdata_d;
    logic [FRAME_W-1:0]        frame_q, frame_d;
    logic [FRAME_W-1:0]        wframe_q, wframe_d;
    logic [CHAN_W-1:0]         chan_q, chan_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      req_q, req_d;
    logic                      overrun_q, overrun_d;
    logic                      sync_err_q, sync_err_d;
    logic [CHAN_W-1:0]         c;
    logic                      last;
    logic                      gap_done;

    always_comb begin
        c          = src.in_sync ? '0 : chan_q;
        last       = src.in_valid && (c == CHAN_W'(NCHAN - 1));
        we_d       = src.in_valid;
        waddr_d    = src.in_valid ? {wframe_q, c} : waddr_q;
        wdata_d    = src.in_valid ? src.in_data : wdata_q;
        chan_d     = !src.in_valid ? chan_q : last ? '0 : c + CHAN_W'(1);
        frame_d    = last ? wframe_q : frame_q;
        wframe_d   = last ? wframe_q + FRAME_W'(1) : wframe_q;
        // the start request is registered so seq_run rises one edge after the last RAM write
        req_d      = last;
        gap_done   = gap_q == GAP_W'(GAP - 1);
        state_d    = state_q;
        gap_d      = '0;
        case (state_q)
            ST_IDLE: state_d = req_q ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = seq_done ? ST_GAP : ST_RUN;
            ST_GAP: begin
                // a request landing on the exit edge is taken straight into RUN
                state_d = gap_done ? (req_q ? ST_RUN : ST_IDLE) : ST_GAP;
                gap_d   = gap_done ? '0 : gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        overrun_d  = (req_q && (state_q == ST_RUN || (state_q == ST_GAP && !gap_done)))
                   || (overrun_q && !clr);
        sync_err_d = (src.in_valid && src.in_sync && chan_q != '0) || (sync_err_q && !clr);
    end

    always_ff @(negedge ck or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            frame_q    <= '1;
            wframe_q   <= '0;
            chan_q     <= '0;
            gap_q      <= '0;
            req_q      <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            frame_q    <= frame_d;
            wframe_q   <= wframe_d;
            chan_q     <= chan_d;
            gap_q      <= gap_d;
            req_q      <= req_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign frame    = frame_q;
    assign seq_run  = state_q == ST_RUN;
    assign overrun  = overrun_q;
    assign sync_err = sync_err_q;
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: table-driven and directed checks of frame_writer.
module tb_frame_writer;
    logic        ck = 1'b1;
    logic        rst;
    logic        clr;
    logic        seq_done;
    logic        we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  frame;
    logic        seq_run;
    logic        overrun;
    logic        sync_err;
    int          total = 0;
    int          bad = 0;

    frame_writer_if src_if();

    frame_writer dut (
        .ck(ck), .rst(rst), .src(src_if), .clr(clr), .seq_done(seq_done),
        .we(we), .waddr(waddr), .wdata(wdata), .frame(frame),
        .seq_run(seq_run), .overrun(overrun), .sync_err(sync_err)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        dn;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        logic [3:0]  e_frame;
        logic        e_run;
    } vec_t;

    vec_t tab [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive inputs at a rising edge, then wait past the falling (active) edge to the next rising edge
    task automatic tick(input logic v, input logic s, input logic [15:0] d, input logic dn, input logic cl);
        src_if.in_valid = v;
        src_if.in_sync  = s;
        src_if.in_data  = d;
        seq_done        = dn;
        clr             = cl;
        @(posedge ck);
    endtask

    task automatic send_frame(input logic [3:0] wf, input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, i == 0, base + 16'(i), 1'b0, 1'b0);
            chk("frm_we", we, 1);
            chk("frm_addr", waddr, {wf, 4'(i)});
            chk("frm_data", wdata, base + 16'(i));
        end
        chk("frm_frame", frame, wf);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            tab[r].v       = r < 8 || (r >= 22 && r <= 29);
            tab[r].s       = r == 0 || r == 22;
            tab[r].d       = !tab[r].v ? 16'h0 : r < 8 ? 16'h1000 + 16'(r) : 16'h2000 + 16'(r - 22);
            tab[r].dn      = r == 28 || r == 31;
            tab[r].e_we    = tab[r].v;
            tab[r].e_addr  = r < 8 ? 8'(r) : r < 22 ? 8'h07 : r <= 29 ? 8'h10 + 8'(r - 22) : 8'h17;
            tab[r].e_data  = r < 8 ? 16'h1000 + 16'(r) : r < 22 ? 16'h1007 : r <= 29 ? 16'h2000 + 16'(r - 22) : 16'h2007;
            tab[r].e_frame = r < 7 ? 4'hF : r < 29 ? 4'h0 : 4'h1;
            tab[r].e_run   = (r >= 8 && r < 28) || r == 30;
        end
        rst = 1'b1;
        src_if.in_valid = 0; src_if.in_sync = 0; src_if.in_data = 0;
        clr = 0; seq_done = 0;
        repeat (2) @(posedge ck);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_frame", frame, 4'hF);
        chk("rst_run", seq_run, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_serr", sync_err, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, i == 0, 16'h5550 + 16'(i), 1'b0, 1'b0);
        chk("pre_rst_addr", waddr, 8'h02);
        chk("pre_rst_we", we, 1);
        src_if.in_valid = 0; src_if.in_sync = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_waddr", waddr, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_frame", frame, 4'hF);
        #1 rst = 1'b0;
        @(posedge ck);
        for (int r = 0; r < 32; r++) begin
            tick(tab[r].v, tab[r].s, tab[r].d, tab[r].dn, 1'b0);
            chk("tab_we", we, tab[r].e_we);
            chk("tab_addr", waddr, tab[r].e_addr);
            chk("tab_data", wdata, tab[r].e_data);
            chk("tab_frame", frame, tab[r].e_frame);
            chk("tab_run", seq_run, tab[r].e_run);
        end
        chk("tab_ovr", overrun, 0);
        chk("tab_serr", sync_err, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("gap_idle_run", seq_run, 0);
        for (int f = 2; f <= 17; f++) begin
            send_frame(f[3:0], 16'(f * 256));
            tick(0, 0, 0, 0, 0);
            chk("wrap_run_hi", seq_run, 1);
            tick(0, 0, 0, 1, 0);
            chk("wrap_run_lo", seq_run, 0);
            tick(0, 0, 0, 0, 0);
            chk("wrap_gap", seq_run, 0);
        end
        chk("wrap_ovr", overrun, 0);
        send_frame(4'h2, 16'h3000);
        tick(0, 0, 0, 0, 0);
        chk("ovr_run1", seq_run, 1);
        chk("ovr_pre", overrun, 0);
        send_frame(4'h3, 16'h3100);
        tick(0, 0, 0, 0, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_run_held", seq_run, 1);
        tick(0, 0, 0, 1, 0);
        chk("ovr_done", seq_run, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        chk("ovr_no_restart", seq_run, 0);
        chk("ovr_frame", frame, 4'h3);
        tick(0, 0, 0, 0, 1);
        chk("ovr_clr", overrun, 0);
        send_frame(4'h4, 16'h3200);
        tick(0, 0, 0, 0, 0);
        chk("ovr2_run", seq_run, 1);
        send_frame(4'h5, 16'h3300);
        tick(0, 0, 0, 0, 1);
        chk("ovr_set_wins", overrun, 1);
        tick(0, 0, 0, 1, 0);
        repeat (2) tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("ovr_clr2", overrun, 0);
        tick(1, 1, 16'h6000, 0, 0);
        tick(1, 0, 16'h6001, 0, 0);
        chk("sync_addr1", waddr, 8'h61);
        chk("sync_pre", sync_err, 0);
        tick(1, 1, 16'hABCD, 0, 0);
        chk("sync_err", sync_err, 1);
        chk("sync_addr", waddr, 8'h60);
        chk("sync_data", wdata, 16'hABCD);
        for (int i = 1; i < 8; i++) begin
            tick(1'b1, 1'b0, 16'h6100 + 16'(i), 1'b0, 1'b0);
            chk("sync_follow", waddr, 8'h60 + 8'(i));
        end
        chk("sync_frame", frame, 4'h6);
        tick(0, 0, 0, 0, 0);
        chk("sync_run", seq_run, 1);
        tick(0, 0, 0, 1, 1);
        chk("sync_clr", sync_err, 0);
        chk("final_ovr", overrun, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
